// File: rtl/nios2_jtag_pkg.sv
// Shared definitions for the Nios II JTAG debug host.
// Holds the host FSM state encoding, default scan-register lengths and the
// number of TMS=1 clocks used to force the target TAP into Test-Logic-Reset.
package nios2_jtag_pkg;

  localparam int IR_W_DEF = 2;
  localparam int DR_W_DEF = 38;
  localparam int TLR_TCKS = 5;

  typedef enum logic [3:0] {
    INIT_TLR,
    INIT_RTI,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAP_IR,
    SHIFT_IR,
    EXIT_UPD_IR,
    CAP_DR,
    SHIFT_DR,
    EXIT_UPD_DR,
    RSP
  } jtag_state_e;

endpackage

// File: rtl/nios2_jtag_tck_gen.sv
// TCK divider: while enabled, produces a square wave with TCK_DIV clk low
// followed by TCK_DIV clk high. Held low with the divider cleared when idle.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   enable      - run the divider
//   tck         - registered TCK output
//   fall_pulse  - high on the clk cycle whose rising edge drops tck to 0
//   rise_pulse  - high on the clk cycle whose rising edge raises tck to 1
module nios2_jtag_tck_gen
  import nios2_jtag_pkg::*;
#(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic fall_pulse,
  output logic rise_pulse
);

  logic [7:0] div_q, div_d;
  logic       tck_q, tck_d;
  logic       wrap;

  assign wrap = enable && (div_q == 8'(TCK_DIV - 1));

  always_comb begin
    div_d = div_q;
    tck_d = tck_q;
    if (!enable) begin
      div_d = '0;
      tck_d = 1'b0;
    end else if (wrap) begin
      div_d = '0;
      tck_d = ~tck_q;
    end else begin
      div_d = div_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck        = tck_q;
  assign rise_pulse = wrap & ~tck_q;
  assign fall_pulse = wrap & tck_q;

endmodule

// File: rtl/nios2_jtag_debug_host.sv
// JTAG host that resets the target TAP, then runs one IR+DR (or DR-only)
// scan per command and returns the captured TDO bits.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   cmd_valid/cmd_ready        - command handshake
//   cmd_skip_ir, cmd_ir, cmd_dr- scan request (bits shifted LSB first)
//   rsp_valid/rsp_ready        - response handshake, held until accepted
//   rsp_ir, rsp_dr             - captured TDO bits (rsp_ir is 0 for DR-only)
//   tck, tms, tdi, tdo         - JTAG pins to/from the target TAP
//
// state       | meaning (TCKs spent, tms driven)
// INIT_TLR    | TLR_TCKS clocks, tms=1: force Test-Logic-Reset
// INIT_RTI    | 1 clock, tms=0: move to Run-Test/Idle
// IDLE        | TAP in Run-Test/Idle, tck stopped, accepting commands
// SEL_DR      | 1 clock, tms=1: RTI -> Select-DR
// SEL_IR      | 1 clock, tms=1: Select-DR -> Select-IR
// CAP_IR      | 2 clocks, tms=0,0: -> Capture-IR -> Shift-IR
// SHIFT_IR    | IR_W clocks, tms=1 on the last bit only
// EXIT_UPD_IR | 2 clocks, tms=1,1: -> Update-IR -> Select-DR
// CAP_DR      | 2 clocks, tms=0,0: -> Capture-DR -> Shift-DR
// SHIFT_DR    | DR_W clocks, tms=1 on the last bit only
// EXIT_UPD_DR | 2 clocks, tms=1,0: -> Update-DR -> RTI
// RSP         | tck stopped, response presented until accepted
module nios2_jtag_debug_host
  import nios2_jtag_pkg::*;
#(
  parameter int TCK_DIV = 4,
  parameter int IR_W    = IR_W_DEF,
  parameter int DR_W    = DR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_skip_ir,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IR_W-1:0] rsp_ir,
  output logic [DR_W-1:0] rsp_dr,
  output logic            tck,
  output logic            tms,
  output logic            tdi,
  input  logic            tdo
);

  localparam int CNT_W = $clog2(DR_W + IR_W + TLR_TCKS + 1);

  jtag_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [IR_W-1:0] ir_sh_q, ir_sh_d;
  logic [DR_W-1:0] dr_sh_q, dr_sh_d;
  logic            skip_q, skip_d;
  logic            tms_q, tms_d;
  logic            tdi_q, tdi_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IR_W-1:0] rsp_ir_q, rsp_ir_d;
  logic [DR_W-1:0] rsp_dr_q, rsp_dr_d;
  logic            tck_en, fall, rise;

  assign tck_en = (state_q != IDLE) && (state_q != RSP);

  nios2_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .enable     (tck_en),
    .tck        (tck),
    .fall_pulse (fall),
    .rise_pulse (rise)
  );

  assign cnt_nxt = cnt_q + CNT_W'(1);

  // All TAP-state moves happen on the falling tck edge, so tms/tdi for the
  // next TCK period are set up a full half-period before the TAP samples them.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_sh_d     = ir_sh_q;
    dr_sh_d     = dr_sh_q;
    skip_d      = skip_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_ir_d    = rsp_ir_q;
    rsp_dr_d    = rsp_dr_q;
    case (state_q)
      INIT_TLR: if (fall) begin
        if (cnt_q == CNT_W'(TLR_TCKS - 1)) begin
          state_d = INIT_RTI;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      INIT_RTI: if (fall) begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      IDLE: if (cmd_valid && cmd_ready_q) begin
        ir_sh_d     = cmd_ir;
        dr_sh_d     = cmd_dr;
        skip_d      = cmd_skip_ir;
        rsp_ir_d    = '0;
        rsp_dr_d    = '0;
        cmd_ready_d = 1'b0;
        cnt_d       = '0;
        tms_d       = 1'b1;
        state_d     = SEL_DR;
      end
      SEL_DR: if (fall) begin
        cnt_d = '0;
        if (skip_q) begin
          state_d = CAP_DR;
          tms_d   = 1'b0;
        end else begin
          state_d = SEL_IR;
          tms_d   = 1'b1;
        end
      end
      SEL_IR: if (fall) begin
        state_d = CAP_IR;
        cnt_d   = '0;
        tms_d   = 1'b0;
      end
      CAP_IR: if (fall) begin
        if (cnt_q == '0) begin
          cnt_d = cnt_nxt;
        end else begin
          state_d = SHIFT_IR;
          cnt_d   = '0;
          tdi_d   = ir_sh_q[0];
          ir_sh_d = ir_sh_q >> 1;
          tms_d   = (IR_W == 1);
        end
      end
      SHIFT_IR: begin
        // Shift captures in from the top so bit k ends at position k.
        if (rise) begin
          rsp_ir_d         = rsp_ir_q >> 1;
          rsp_ir_d[IR_W-1] = tdo;
        end
        if (fall) begin
          if (cnt_q == CNT_W'(IR_W - 1)) begin
            state_d = EXIT_UPD_IR;
            cnt_d   = '0;
            tdi_d   = 1'b0;
            tms_d   = 1'b1;
          end else begin
            cnt_d   = cnt_nxt;
            tdi_d   = ir_sh_q[0];
            ir_sh_d = ir_sh_q >> 1;
            tms_d   = (cnt_nxt == CNT_W'(IR_W - 1));
          end
        end
      end
      EXIT_UPD_IR: if (fall) begin
        if (cnt_q == '0) begin
          cnt_d = cnt_nxt;
        end else begin
          state_d = CAP_DR;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end
      end
      CAP_DR: if (fall) begin
        if (cnt_q == '0) begin
          cnt_d = cnt_nxt;
        end else begin
          state_d = SHIFT_DR;
          cnt_d   = '0;
          tdi_d   = dr_sh_q[0];
          dr_sh_d = dr_sh_q >> 1;
          tms_d   = (DR_W == 1);
        end
      end
      SHIFT_DR: begin
        if (rise) begin
          rsp_dr_d         = rsp_dr_q >> 1;
          rsp_dr_d[DR_W-1] = tdo;
        end
        if (fall) begin
          if (cnt_q == CNT_W'(DR_W - 1)) begin
            state_d = EXIT_UPD_DR;
            cnt_d   = '0;
            tdi_d   = 1'b0;
            tms_d   = 1'b1;
          end else begin
            cnt_d   = cnt_nxt;
            tdi_d   = dr_sh_q[0];
            dr_sh_d = dr_sh_q >> 1;
            tms_d   = (cnt_nxt == CNT_W'(DR_W - 1));
          end
        end
      end
      EXIT_UPD_DR: if (fall) begin
        if (cnt_q == '0) begin
          cnt_d = cnt_nxt;
          tms_d = 1'b0;
        end else begin
          state_d = RSP;
          cnt_d   = '0;
        end
      end
      RSP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = INIT_TLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT_TLR;
      cnt_q       <= '0;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
      skip_q      <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ir_q    <= '0;
      rsp_dr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ir_sh_q     <= ir_sh_d;
      dr_sh_q     <= dr_sh_d;
      skip_q      <= skip_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ir_q    <= rsp_ir_d;
      rsp_dr_q    <= rsp_dr_d;
    end
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_ir    = rsp_ir_q;
  assign rsp_dr    = rsp_dr_q;

endmodule

// File: doc/nios2_jtag_debug_host.md
NIOS2_JTAG_DEBUG_HOST -- requirements
Module: nios2_jtag_debug_host

Interface
REQ-001 SHALL have parameter TCK_DIV, default 4: clk cycles per TCK half-period, legal range 2..255.
REQ-002 SHALL have parameter IR_W, default 2: instruction register length.
REQ-003 SHALL have parameter DR_W, default 38: data register length, matching the debug slave jdo/sr width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  reset, synchronous and active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  host idle in Run-Test/Idle and able to accept a command.
REQ-008 cmd_skip_ir  in  1  1 = DR scan only; 0 = IR scan then DR scan.
REQ-009 cmd_ir  in  IR_W  IR value shifted, LSB first.
REQ-010 cmd_dr  in  DR_W  DR value shifted, LSB first.
REQ-011 rsp_valid  out  1  response held until accepted.
REQ-012 rsp_ready  in  1  response accept.
REQ-013 rsp_ir  out  IR_W  TDO bits captured during Shift-IR; 0 when skipped.
REQ-014 rsp_dr  out  DR_W  TDO bits captured during Shift-DR.
REQ-015 tck / tms / tdi  out  1 each  JTAG drive to the target TAP.
REQ-016 tdo  in  1  JTAG return from the target TAP.

Function
REQ-017 SHALL generate tck as a free-running-while-busy square wave: TCK_DIV clk low, TCK_DIV clk high; tck held at 0 when not busy.
REQ-018 SHALL update tms/tdi only on the clk edge where tck falls to 0, and sample tdo only on the clk edge where tck rises to 1.
REQ-019 Init sequence: after reset, 5 TCKs with tms=1 (Test-Logic-Reset), then 1 TCK with tms=0 (to Run-Test/Idle); cmd_ready SHALL stay 0 until this completes (48 clk at defaults).
REQ-020 Command SHALL be accepted on a cycle with cmd_valid & cmd_ready; cmd_ir/cmd_dr/cmd_skip_ir SHALL be latched then; cmd_ready SHALL drop the next cycle.
REQ-021 FSM states: INIT_TLR, INIT_RTI, IDLE, SEL_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT_UPD_IR, CAP_DR, SHIFT_DR, EXIT_UPD_DR, RSP. Each TAP state SHALL consume exactly one TCK period.
REQ-022 Full-scan tms sequence per TCK SHALL be: 1,1,0,0, then IR_W shift bits (tms=0, except tms=1 on the last), then 1,1,0,0, then DR_W shift bits (tms=0, except 1 on the last), then 1,0. Total: 10+IR_W+DR_W TCKs (50 at defaults, 400 clk).
REQ-023 Skip-IR tms sequence SHALL be: 1,0,0, then DR_W shift bits, then 1,0. Total: 5+DR_W TCKs.
REQ-024 tdi SHALL present shift bit k during the TCK whose rising edge shifts bit k; tdi=0 outside shift states.
REQ-025 The tdo sample taken on the rising edge that shifts bit k SHALL land in rsp_ir[k] / rsp_dr[k].
REQ-026 rsp_valid SHALL rise one clk after the final (tms=0) TCK falls; rsp_ir and rsp_dr SHALL be stable while rsp_valid is high.
REQ-027 cmd_ready SHALL be 0 while rsp_valid is high. When rsp_valid & rsp_ready, rsp_valid SHALL drop and cmd_ready SHALL rise on the next cycle.
REQ-028 cmd_valid asserted while cmd_ready=0 SHALL be ignored, with no latching.
REQ-029 IR_W=1 or DR_W=1 SHALL give a single-shift state, with tms=1 on that bit.

Reset
REQ-030 reset SHALL take priority over all activity, including mid-scan. Next-cycle values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_ir=0, rsp_dr=0, FSM=INIT_TLR, divider=0.
REQ-031 Reset mid-scan SHALL discard the command with no response and rerun the init sequence.

Structure
REQ-032 Package nios2_jtag_pkg SHALL hold the FSM state enum, default IR_W/DR_W values, and the TLR_TCKS=5 constant.
REQ-033 One sub-module, nios2_jtag_tck_gen, SHALL implement the divider. It SHALL provide enable in and tck, fall_pulse and rise_pulse out.

Verification
REQ-034 Reset release, TCK_DIV=4: tms=1 for exactly 5 TCKs then 0 for 1 TCK; cmd_ready rises at clk 48±1.
REQ-035 Full scan, cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A, tdo looped from tdi by a TAP model: rsp_ir=2'b01, rsp_dr=38'h2A_5A5A_5A5A; 50 TCKs; tms trace matches REQ-022.
REQ-036 Skip-IR scan, TAP model returning a fixed capture 38'h3F_0000_0001: rsp_ir=0, rsp_dr=38'h3F_0000_0001; 43 TCKs.
REQ-037 Backpressure: rsp_ready held 0 for 20 clk with cmd_valid held 1: rsp_valid stays 1, cmd_ready stays 0, no second scan; after rsp_ready=1 the next command is accepted within 2 clk.
REQ-038 reset asserted at TCK 20 of a full scan: all outputs at reset values next clk, no rsp_valid, init sequence repeats.
REQ-039 TCK_DIV=2, DR_W=1, IR_W=1: tck period 4 clk, tms trace 1,1,0,0,1,1,1,0,0,1,1,0; a TAP model reaches Run-Test/Idle.
